// File: rtl/haraka_pkg.sv
// Shared types, constants and GF(2^8) helpers for the Haraka-512 round sequencer.
package haraka_pkg;

    typedef enum logic [2:0] {IDLE, FEED, CAPT, MIX, DONE} state_t;

    localparam int DEF_ROUNDS        = 5;
    localparam int DEF_AES_PER_ROUND = 2;
    localparam int RC_ENTRIES        = 40;

    // Round constants, indexed by LANES*AES_PER_ROUND*r + LANES*s + lane.
    localparam logic [7:0] RC_TABLE [RC_ENTRIES] = '{
        8'h9d, 8'h7b, 8'h81, 8'h75, 8'hf0, 8'hfe, 8'hc5, 8'hb2,
        8'h0a, 8'hc0, 8'h20, 8'he6, 8'h4c, 8'h70, 8'h84, 8'h06,
        8'h17, 8'hf7, 8'h08, 8'h2f, 8'ha4, 8'h6b, 8'h0f, 8'h64,
        8'h6b, 8'ha0, 8'hf3, 8'h88, 8'he1, 8'hb4, 8'h66, 8'h8b,
        8'h14, 8'h91, 8'h02, 8'h9f, 8'h60, 8'h9d, 8'h02, 8'hcf
    };

    // MIX4: output 32-bit word j takes input word MIX4_IDX[j].
    localparam int MIX4_IDX [16] = '{3, 11, 7, 15, 8, 0, 12, 4, 9, 1, 13, 5, 2, 10, 6, 14};

    function automatic logic [7:0] aes_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aes_xtime(aa);
        end
        return p;
    endfunction

    // S-box as inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] y;
        sq = x;
        y  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            y  = gf_mul(y, sq);
        end
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/haraka_aes_round.sv
// One AES lane: registered input, then SubBytes/ShiftRows/MixColumns and a
// round-constant XOR on the combinational output side.
module haraka_aes_round
    import haraka_pkg::*;
#(
    parameter int RC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_encrypt,
    input  logic [127:0]    i_data,
    input  logic [RC_W-1:0] i_rc,
    output logic [127:0]    o_data
);

    logic [127:0] r_in;
    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_key;

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a3, a2, a1, a0} = c;
        return {aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3),
                a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3,
                a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3,
                aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    // Lane input register, loaded while the sequencer is feeding the lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_in <= '0;
        else if (i_load) r_in <= i_data;
    end

    // Byte b sits at [8b +: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
    always_comb begin
        w_sub   = '0;
        w_shift = '0;
        w_mix   = '0;
        for (int b = 0; b < 16; b++)
            w_sub[8*b +: 8] = aes_sbox(r_in[8*b +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_shift[8*(4*c+r) +: 8] = w_sub[8*(4*((c+r)%4)+r) +: 8];
        for (int c = 0; c < 4; c++)
            w_mix[32*c +: 32] = mix_col(w_shift[32*c +: 32]);
    end

    assign w_key  = {{(128-RC_W){1'b0}}, i_rc};
    assign o_data = i_encrypt ? (w_mix ^ w_key) : (r_in ^ w_key);

endmodule

// File: rtl/haraka_mix4.sv
// MIX4: fixed 32-bit word permutation across the four 128-bit lanes.
module haraka_mix4
    import haraka_pkg::*;
(
    input  logic [511:0] i_st,
    output logic [511:0] o_st
);

    // Pure wiring: each output word selects one input word from the table.
    always_comb begin
        o_st = '0;
        for (int j = 0; j < 16; j++)
            o_st[32*j +: 32] = i_st[32*MIX4_IDX[j] +: 32];
    end

endmodule

// File: rtl/haraka_round_ctrl.sv
// Haraka-512 permutation sequencer: four AES lanes stepped ROUNDS times with
// MIX4 between rounds, result fed forward with the original block.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// FEED  | lane registers sample the current state
// CAPT  | lane outputs (with round constants) written back to the state
// MIX   | MIX4 applied; last round also produces out_data
// DONE  | out_valid high until downstream accepts
module haraka_round_ctrl
    import haraka_pkg::*;
#(
    parameter int ROUNDS        = DEF_ROUNDS,
    parameter int AES_PER_ROUND = DEF_AES_PER_ROUND,
    parameter int LANES         = 4,
    parameter int RC_W          = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         busy
);

    localparam int R_W   = $clog2(ROUNDS + 1);
    localparam int S_W   = $clog2(AES_PER_ROUND + 1);
    localparam int IDX_W = $clog2(RC_ENTRIES);

    if (LANES != 4) begin : g_bad_lanes
        $error("haraka_round_ctrl: MIX4 requires exactly 4 lanes");
    end
    if (LANES * AES_PER_ROUND * ROUNDS > RC_ENTRIES) begin : g_bad_rc
        $error("haraka_round_ctrl: round constant table too small");
    end

    state_t         r_state;
    logic [R_W-1:0] r_round;
    logic [S_W-1:0] r_step;
    logic [511:0]   r_st;
    logic [511:0]   r_ff;
    logic [511:0]   r_out_data;
    logic           r_out_valid;
    logic           r_in_ready;
    logic           r_busy;

    logic [511:0]   w_lane_out;
    logic [511:0]   w_mix;
    logic           w_load;

    assign w_load = (r_state == FEED);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] w_idx;
        logic [RC_W-1:0]  w_rc;

        // Constant is held across FEED and CAPT so it is stable when captured.
        always_comb begin
            w_idx = IDX_W'(LANES * AES_PER_ROUND * int'(r_round) + LANES * int'(r_step) + l);
            w_rc  = '0;
            if (r_state == FEED || r_state == CAPT)
                w_rc = RC_W'(RC_TABLE[w_idx]);
        end

        haraka_aes_round #(.RC_W(RC_W)) u_aes (
            .clk       (clk),
            .rst       (rst),
            .i_load    (w_load),
            .i_encrypt (1'b1),
            .i_data    (r_st[128*l +: 128]),
            .i_rc      (w_rc),
            .o_data    (w_lane_out[128*l +: 128])
        );
    end

    haraka_mix4 u_mix4 (
        .i_st (r_st),
        .o_st (w_mix)
    );

    // Sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_round     <= '0;
            r_step      <= '0;
            r_st        <= '0;
            r_ff        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_st       <= in_data;
                        r_ff       <= in_data;
                        r_round    <= '0;
                        r_step     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= FEED;
                    end
                end
                FEED: r_state <= CAPT;
                CAPT: begin
                    r_st <= w_lane_out;
                    if (r_step < S_W'(AES_PER_ROUND - 1)) begin
                        r_step  <= r_step + 1'b1;
                        r_state <= FEED;
                    end else begin
                        r_step  <= '0;
                        r_state <= MIX;
                    end
                end
                MIX: begin
                    r_st <= w_mix;
                    if (r_round < R_W'(ROUNDS - 1)) begin
                        r_round <= r_round + 1'b1;
                        r_state <= FEED;
                    end else begin
                        r_out_data  <= w_mix ^ r_ff;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule
